// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing stage for the glyph-mode display. Produces the horizontal and
// vertical raster counters, sync pulses, the active-video flag, single-cycle
// line/frame strobes and an optional synchronous completed-frame counter.
// Default timing is 640x480@60 (25.175 MHz nominal pixel clock).
//
// Every output is a register loaded on the same edge as the counters, so sync,
// display_on and the strobes always describe the current hpos/vpos.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   ce           in   count enable; 0 freezes counters, syncs and display_on
//   hpos  [9:0]  out  horizontal position, 0..H_TOTAL-1
//   vpos  [9:0]  out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active level = SYNC_POL
//   vsync        out  vertical sync, active level = SYNC_POL
//   display_on   out  1 inside the active area
//   line_start   out  one-cycle strobe after each advance into hpos==0
//   frame_start  out  one-cycle strobe after each advance into (0,0)
//   frame_cnt [9:0] out completed-frame counter
//
// Build option:
//   VGA_TIMING_FRAME_CNT_EN  when defined, frame_cnt counts completed frames
//                            (wrapping 1023 -> 0); when undefined frame_cnt
//                            is tied to 0 and no counter register exists.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // 11-bit bounds so an interval ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_LAST_W     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST_W     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP_END   = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP_END   = 11'(V_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG   = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0]  H_LAST       = H_LAST_W[9:0];
    localparam logic [9:0]  V_LAST       = V_LAST_W[9:0];

    // Counters are 10 bits wide; reject timings that cannot be represented
    generate
        if (H_TOTAL > 1024) begin : g_h_total_check
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_check
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    logic [9:0] hpos_r;
    logic [9:0] vpos_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       display_on_r;
    logic       line_start_r;
    logic       frame_start_r;

    // Next-state values
    logic [9:0] hpos_nxt_s;
    logic [9:0] vpos_nxt_s;
    logic       hsync_nxt_s;
    logic       vsync_nxt_s;
    logic       display_on_nxt_s;
    logic       line_start_nxt_s;
    logic       frame_start_nxt_s;
    logic       h_sync_act_s;
    logic       v_sync_act_s;

    // Raster position advance: hpos wraps at H_TOTAL-1, vpos steps only on that wrap
    always_comb begin
        hpos_nxt_s = hpos_r;
        vpos_nxt_s = vpos_r;
        if (ce) begin
            if (hpos_r == H_LAST) begin
                hpos_nxt_s = 10'd0;
                if (vpos_r == V_LAST) begin
                    vpos_nxt_s = 10'd0;
                end else begin
                    vpos_nxt_s = vpos_r + 10'd1;
                end
            end else begin
                hpos_nxt_s = hpos_r + 10'd1;
                vpos_nxt_s = vpos_r;
            end
        end else begin
            hpos_nxt_s = hpos_r;
            vpos_nxt_s = vpos_r;
        end
    end

    // Decode sync, active area and strobes from the position being loaded, so
    // the registered flags line up with the registered counters
    always_comb begin
        h_sync_act_s      = ({1'b0, hpos_nxt_s} >= H_SYNC_BEG) &&
                            ({1'b0, hpos_nxt_s} <  H_SYNC_END);
        v_sync_act_s      = ({1'b0, vpos_nxt_s} >= V_SYNC_BEG) &&
                            ({1'b0, vpos_nxt_s} <  V_SYNC_END);
        display_on_nxt_s  = ({1'b0, hpos_nxt_s} < H_DISP_END) &&
                            ({1'b0, vpos_nxt_s} < V_DISP_END);
        if (h_sync_act_s) begin
            hsync_nxt_s = SYNC_POL;
        end else begin
            hsync_nxt_s = ~SYNC_POL;
        end
        if (v_sync_act_s) begin
            vsync_nxt_s = SYNC_POL;
        end else begin
            vsync_nxt_s = ~SYNC_POL;
        end
        // Strobes fire only on an actual advance, so ce=0 clears them
        if (ce) begin
            line_start_nxt_s  = (hpos_nxt_s == 10'd0);
            frame_start_nxt_s = (hpos_nxt_s == 10'd0) && (vpos_nxt_s == 10'd0);
        end else begin
            line_start_nxt_s  = 1'b0;
            frame_start_nxt_s = 1'b0;
        end
    end

    // Raster counter and output flag registers; reset parks at the last pixel
    // so the first enabled edge lands on (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_r        <= H_LAST;
            vpos_r        <= V_LAST;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            display_on_r  <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hpos_r        <= hpos_nxt_s;
            vpos_r        <= vpos_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            display_on_r  <= display_on_nxt_s;
            line_start_r  <= line_start_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [9:0] frame_cnt_r;
    logic       started_r;

    // Completed-frame counter; the entry into (0,0) straight out of reset is
    // not a completed frame, so counting is armed only after the first advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 10'd0;
            started_r   <= 1'b0;
        end else begin
            if (ce) begin
                started_r <= 1'b1;
            end else begin
                started_r <= started_r;
            end
            if (frame_start_nxt_s && started_r) begin
                frame_cnt_r <= frame_cnt_r + 10'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 10'd0;
`endif

    assign hpos        = hpos_r;
    assign vpos        = vpos_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign display_on  = display_on_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clk/rst_n/ce: dut_a uses default 640x480 timing with
// active-low syncs, dut_b a tiny 8x6 raster with active-high syncs so whole
// frames (and 1024 of them) fit in a short run. A reference model derives
// every output from the number of enabled edges since reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       ce;

    logic [9:0] a_hpos, a_vpos, a_fc;
    logic       a_hs, a_vs, a_disp, a_ls, a_fs;
    logic [9:0] b_hpos, b_vpos, b_fc;
    logic       b_hs, b_vs, b_disp, b_ls, b_fs;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state: enabled edges since reset, and whether the last edge advanced
    int ticks;
    bit adv;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hs), .vsync(a_vs),
        .display_on(a_disp), .line_start(a_ls), .frame_start(a_fs),
        .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_disp), .line_start(b_ls), .frame_start(b_fs),
        .frame_cnt(b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position is (ticks-1) modulo the frame size, laid out row-major
    function automatic logic [34:0] model(input int hd, input int hf, input int hsw, input int hb,
                                          input int vd, input int vf, input int vsw, input int vb,
                                          input bit pol, input int t, input bit a);
        int ht, vt, frame, p, h, v, fc;
        logic hs, vs, disp, ls, fs;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vb;
        frame = ht * vt;
        p     = (t + frame - 1) % frame;
        h     = p % ht;
        v     = p / ht;
        hs    = (h >= hd + hf && h < hd + hf + hsw) ? pol : ~pol;
        vs    = (v >= vd + vf && v < vd + vf + vsw) ? pol : ~pol;
        disp  = (h < hd) && (v < vd);
        ls    = a && (h == 0);
        fs    = a && (p == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc    = (t == 0) ? 0 : ((t - 1) / frame) % 1024;
`else
        fc    = 0;
`endif
        return {10'(h), 10'(v), hs, vs, disp, ls, fs, 10'(fc)};
    endfunction

    task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     nm, $time, act[34:25], act[24:15], act[14], act[13], act[12], act[11], act[10], act[9:0],
                     exp[34:25], exp[24:15], exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:0]);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    // Model update, mirroring only the externally visible rules of reset and enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks <= 0;
            adv   <= 1'b0;
        end else begin
            if (ce) ticks <= ticks + 1;
            adv <= ce;
        end
    end

    // Continuous comparison of both instances against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", {a_hpos, a_vpos, a_hs, a_vs, a_disp, a_ls, a_fs, a_fc},
                  model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ticks, adv));
            check("model_b", {b_hpos, b_vpos, b_hs, b_vs, b_disp, b_ls, b_fs, b_fc},
                  model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, ticks, adv));
        end
    end

    typedef struct {
        bit ce;
        int n;
        int h;
        int v;
        bit hs;
        bit disp;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int fs_cnt, ls_cnt, vs_cnt;
        bit reached;

        // Hand-derived checkpoints for dut_a, applied back to back after reset
        tbl[0]  = '{1'b1,   1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0,   1,   0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1,   1,   1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 654, 655, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0,   5, 655, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1,   1, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1,  95, 751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1,   1, 752, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1,  47, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1,   1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0,   1,   0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 639, 639, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1,   1, 640, 1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        ce    = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_a", {a_hpos, a_vpos, a_hs, a_vs, a_disp, a_ls, a_fs, a_fc},
              {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
        check("reset_b", {b_hpos, b_vpos, b_hs, b_vs, b_disp, b_ls, b_fs, b_fc},
              {10'd7, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            ce = tbl[i].ce;
            repeat (tbl[i].n) @(negedge clk);
            check($sformatf("table_%0d", i),
                  {a_hpos, a_vpos, a_hs, a_vs, a_disp, a_ls, a_fs, a_fc},
                  {10'(tbl[i].h), 10'(tbl[i].v), tbl[i].hs, 1'b1, tbl[i].disp,
                   tbl[i].ls, tbl[i].fs, 10'd0});
        end

        // Randomised enable pattern, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end

        // Asynchronous reset while both dut_b syncs are active
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;
        repeat (38) @(negedge clk);
        check("b_syncs_active", {b_hpos, b_vpos, b_hs, b_vs, b_disp, b_ls, b_fs, b_fc},
              {10'd5, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", {a_hpos, a_vpos, a_hs, a_vs, a_disp, a_ls, a_fs, a_fc},
              {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
        check("async_rst_b", {b_hpos, b_vpos, b_hs, b_vs, b_disp, b_ls, b_fs, b_fc},
              {10'd7, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
        @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;

        // 1024 full dut_b frames with ce held high
        fs_cnt  = 0;
        ls_cnt  = 0;
        vs_cnt  = 0;
        reached = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (b_fs) fs_cnt++;
            if (b_ls) ls_cnt++;
            if (b_vs) vs_cnt++;
            if (ticks == 49152) begin
                reached = 1'b1;
                break;
            end
        end
        check_int("frame_run_done", int'(reached), 1);
        check_int("frame_start_count", fs_cnt, 1024);
        check_int("line_start_count", ls_cnt, 6144);
        check_int("vsync_active_count", vs_cnt, 8192);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_int("frame_cnt_max", int'(b_fc), 1023);
`else
        check_int("frame_cnt_max", int'(b_fc), 0);
`endif
        @(negedge clk);
        check_int("frame_cnt_wrap", int'(b_fc), 0);
        check_int("frame_start_wrap", int'(b_fs), 1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
